// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the step_ctrl clock-enable front end.
package step_ctrl_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF           = 16;
    localparam int DIV_W               = 4;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser, counter debounce and registered rising-edge strobe
// for one bouncy input.
module debounce_sync
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = (sync2 != level);
    assign accept = differ && (cnt == LAST);

    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // blocking assignments would collapse the synchroniser into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            cnt        <= (!differ || accept) ? '0 : cnt + CW'(1);
            level      <= level ^ accept;
            rise_pulse <= accept && !level;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-enable generator: single-step on debounced button presses or
// free-run at a switch-selected period, with an issued-enable counter.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             ext_clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             run_mode,
    input  logic [3:0]       run_div,
    input  logic             halt,
    output logic             btn_level,
    output logic             step_pulse,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count
);

    logic             mode_s1;
    logic             mode_s2;
    logic [DIV_W-1:0] div_s1;
    logic [DIV_W-1:0] div_s2;

    mode_e            state;
    mode_e            state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_lim;
    logic             tick_q;
    logic             step_d;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (ext_clk),
        .rst_n     (reset),
        .raw       (btn_raw),
        .level     (btn_level),
        .rise_pulse(step_pulse)
    );

    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cpu_en     = 1'b0;
        case (state)
            MODE_STEP: begin
                if (mode_s2) state_next = MODE_RUN;
                cpu_en = step_d && !halt;
            end
            MODE_RUN: begin
                if (!mode_s2) state_next = MODE_STEP;
                cpu_en = tick_q && !halt;
            end
            default: state_next = MODE_STEP;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset) begin
        if (!reset) begin
            mode_s1    <= 1'b0;
            mode_s2    <= 1'b0;
            div_s1     <= '0;
            div_s2     <= '0;
            state      <= MODE_STEP;
            div_cnt    <= '0;
            div_lim    <= '0;
            tick_q     <= 1'b0;
            step_d     <= 1'b0;
            step_count <= '0;
        end else begin
            mode_s1 <= run_mode;
            mode_s2 <= mode_s1;
            div_s1  <= run_div;
            div_s2  <= div_s1;
            state   <= state_next;
            step_d  <= step_pulse;

            // The period limit is only reloaded at a wrap or while idle, so a
            // switch change never truncates a period in progress.
            if (state != state_next || state == MODE_STEP) begin
                div_cnt <= '0;
                div_lim <= div_s2;
            end else if (div_cnt == div_lim) begin
                div_cnt <= '0;
                div_lim <= div_s2;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            tick_q <= (state == MODE_RUN) && (div_cnt == '0);

            if (cpu_en) step_count <= step_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: stimulus pushes expected enable and strobe
// events into queues; a negedge monitor pops and compares them.
module tb_step_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_raw;
    logic        run_mode;
    logic [3:0]  run_div;
    logic        halt;
    logic        btn_level;
    logic        step_pulse;
    logic        cpu_en;
    logic [15:0] step_count;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } en_ev_t;

    en_ev_t      en_q[$];
    int          step_q[$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [15:0] exp_count;

    step_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (16)
    ) dut (
        .ext_clk   (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .run_mode  (run_mode),
        .run_div   (run_div),
        .halt      (halt),
        .btn_level (btn_level),
        .step_pulse(step_pulse),
        .cpu_en    (cpu_en),
        .step_count(step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every cpu_en / step_pulse cycle must match the head of its queue.
    always @(negedge clk) begin
        en_ev_t e;
        if (reset) begin
            if (cpu_en) begin
                if (en_q.size() == 0) begin
                    check("cpu_en_unexpected", 64'(cpu_en), 64'd0);
                end else begin
                    e = en_q.pop_front();
                    check("cpu_en_cycle", 64'(cyc), 64'(e.cyc));
                    check("step_count_at_en", 64'(step_count), 64'(e.cnt));
                end
            end else if (en_q.size() > 0 && en_q[0].cyc <= cyc) begin
                e = en_q.pop_front();
                check("cpu_en_missing", 64'(cpu_en), 64'd1);
            end

            if (step_pulse) begin
                if (step_q.size() == 0) begin
                    check("step_pulse_unexpected", 64'(step_pulse), 64'd0);
                end else begin
                    check("step_pulse_cycle", 64'(cyc), 64'(step_q.pop_front()));
                    check("btn_level_at_pulse", 64'(btn_level), 64'd1);
                end
            end else if (step_q.size() > 0 && step_q[0] <= cyc) begin
                void'(step_q.pop_front());
                check("step_pulse_missing", 64'(step_pulse), 64'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Level sampled first at the next edge; accepted 17 edges later.
    task automatic press(input int len, input bit halt_it);
        int n;
        n = cyc;
        btn_raw = 1'b1;
        step_q.push_back(n + 18);
        if (!halt_it) begin
            en_q.push_back('{cyc: n + 19, cnt: exp_count});
            exp_count++;
        end
        for (int i = 1; i <= len; i++) begin
            tick(1);
            if (halt_it && cyc == n + 17) halt = 1'b1;
            if (halt_it && cyc == n + 21) halt = 1'b0;
        end
        btn_raw = 1'b0;
        tick(40);
    endtask

    task automatic glitch(input int len);
        btn_raw = 1'b1;
        tick(len);
        btn_raw = 1'b0;
        tick(30);
        check("glitch_btn_level", 64'(btn_level), 64'd0);
    endtask

    // Enables at n+4 + i*(div+1) while RUN is held (mode seen 3 edges late).
    task automatic run_phase(input int div, input int ncyc, input int hoff);
        int n;
        n = cyc;
        run_mode = 1'b1;
        run_div  = 4'(div);
        for (int c = n + 4; c < n + ncyc + 3; c += div + 1) begin
            if (!(hoff > 0 && c >= n + hoff && c < n + hoff + 5)) begin
                en_q.push_back('{cyc: c, cnt: exp_count});
                exp_count++;
            end
        end
        for (int i = 1; i <= ncyc; i++) begin
            tick(1);
            if (hoff > 0 && cyc == n + hoff)     halt = 1'b1;
            if (hoff > 0 && cyc == n + hoff + 5) halt = 1'b0;
        end
        run_mode = 1'b0;
        tick(6);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = '0;
        reset     = 1'b0;
        btn_raw   = 1'b1;
        run_mode  = 1'b1;
        run_div   = 4'd0;
        halt      = 1'b0;

        // Reset with button held and free-run requested.
        tick(4);
        check("rst_btn_level", 64'(btn_level), 64'd0);
        check("rst_step_pulse", 64'(step_pulse), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_step_count", 64'(step_count), 64'd0);
        run_mode = 1'b0;
        tick(1);
        reset = 1'b1;
        step_q.push_back(cyc + 18);
        en_q.push_back('{cyc: cyc + 19, cnt: exp_count});
        exp_count++;
        tick(36);
        btn_raw = 1'b0;
        tick(40);
        check("held_press_count", 64'(step_count), 64'd1);

        // Single-step presses.
        for (int i = 0; i < 3; i++) press(36, 1'b0);
        check("three_press_count", 64'(step_count), 64'd4);

        // Glitch rejection then a clean press.
        glitch(1);
        glitch(13);
        check("glitch_count", 64'(step_count), 64'd4);
        press(36, 1'b0);
        check("post_glitch_count", 64'(step_count), 64'd5);

        // Free-run: period 4 for 40 cycles (10 enables), then continuous with halt.
        run_phase(3, 40, 0);
        check("run_div3_count", 64'(step_count), 64'd15);
        run_phase(0, 20, 8);
        check("run_div0_halt_count", 64'(step_count), 64'(exp_count));

        // Halt swallows a step pulse.
        press(36, 1'b1);
        check("halted_press_count", 64'(step_count), 64'(exp_count));

        // Wrap: run up to 0xFFFE, then two presses.
        run_phase(0, int'(16'hFFFE - exp_count) + 1, 0);
        check("preset_fffe", 64'(step_count), 64'hFFFE);
        press(36, 1'b0);
        press(36, 1'b0);
        check("wrap_to_zero", 64'(step_count), 64'd0);

        // Reset while the button is accepted and held.
        btn_raw = 1'b1;
        step_q.push_back(cyc + 18);
        en_q.push_back('{cyc: cyc + 19, cnt: exp_count});
        exp_count++;
        tick(25);
        check("pre_reset_level", 64'(btn_level), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_btn_level", 64'(btn_level), 64'd0);
        check("midrst_step_count", 64'(step_count), 64'd0);
        check("midrst_cpu_en", 64'(cpu_en), 64'd0);
        exp_count = '0;
        btn_raw   = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(40);
        check("post_rst_level", 64'(btn_level), 64'd0);
        check("post_rst_count", 64'(step_count), 64'd0);

        check("en_queue_drained", 64'(en_q.size()), 64'd0);
        check("step_queue_drained", 64'(step_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Front-end clock-enable generator that sits directly upstream of the computer top level.
- Conditions the raw btnd push-button and switch inputs: two-flop synchronisation, counter-based debounce, and a single-cycle step strobe on each debounced press.
- Drives the CPU-wide clock enable in two modes: single-step (one enable pulse per debounced press) and free-run (periodic enable at a switch-selected rate).
- Counts issued enables for display on the seven-segment path.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles needed to accept a button level change; legal range 2..65535.
- CNT_W, 16: width of step_count.

Ports:
- ext_clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- btn_raw  in  1  raw, bouncy push-button (btnd).
- run_mode  in  1  raw switch: 0 = single-step, 1 = free-run.
- run_div  in  4  raw switch: free-run enable period minus one, in cycles.
- halt  in  1  synchronous CPU halt; when 1, cpu_en is forced to 0.
- btn_level  out  1  debounced button level.
- step_pulse  out  1  one-cycle strobe on each debounced rising edge.
- cpu_en  out  1  CPU clock enable.
- step_count  out  CNT_W  number of cycles in which cpu_en was 1; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - btn_level=0, step_pulse=0, cpu_en=0, step_count=0.
  - Synchronisers, debounce counter and divider are cleared; FSM goes to STEP.
  - Reset release takes effect at the first ext_clk edge with reset=1.
- Synchronisation:
  - btn_raw, run_mode and run_div each pass through a 2-flop synchroniser.
  - Values sampled at edge k are visible to the logic at edge k+2.
- Debounce:
  - A counter increments while the synchronised button differs from btn_level.
  - The counter clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles at that edge and the counter clears.
  - Latency: a clean level change sampled at edge k appears on btn_level at edge k+1+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- step_pulse:
  - Registered; high for exactly the one cycle in which btn_level goes 0->1.
  - A release (1->0) produces nothing.
- Mode FSM, states STEP and RUN, decided by the synchronised run_mode:
  - STEP -> RUN when run_mode=1.
  - RUN -> STEP when run_mode=0.
  - The transition takes one cycle. The divider clears on every transition.
- STEP state:
  - cpu_en = step_pulse registered one cycle later, i.e. exactly one enable per press.
  - An enable pulse already in flight when the FSM leaves STEP is dropped.
- RUN state:
  - The divider counts 0..run_div_s and wraps.
  - cpu_en=1 in the cycle after the divider equals 0, giving a period of run_div_s+1 cycles. run_div_s=0 gives cpu_en constantly 1.
  - step_pulse is ignored for cpu_en but still drives its own output.
  - A run_div change takes effect at the next divider wrap.
- halt:
  - When halt=1, cpu_en is 0 that cycle in both modes.
  - A step pulse that coincides with halt is lost, not queued.
  - The divider keeps counting during halt.
- step_count:
  - Increments by 1 at each edge where cpu_en=1.
  - Wraps from all-ones to 0 with no flag.
- Button held through reset release: btn_level starts at 0, so the held button is accepted as a new press after the normal debounce latency.
- Button press and mode change at the same time: both are processed independently; the FSM state at the cycle of the pulse decides whether cpu_en fires.

Decomposition:
- Package step_ctrl_pkg holds:
  - mode state enum {MODE_STEP, MODE_RUN};
  - DEBOUNCE_CYCLES_DEF=16;
  - CNT_W_DEF=16.
- One sub-module, debounce_sync (2-flop synchroniser plus debounce counter plus edge strobe), parameterised by DEBOUNCE_CYCLES.
- debounce_sync outputs level and rise_pulse, and is instantiated once for btn_raw.
- The switch synchronisers stay inline.

Test Plan:
- Reset: hold reset=0 with btn_raw=1, run_mode=1 -> all outputs 0; after release, btn_level rises exactly 1+16 edges after the first post-reset sample edge.
- Single-step, clean presses: run_mode=0, three 36-cycle presses separated by 40 cycles -> exactly 3 step_pulse, 3 cpu_en pulses each one cycle after step_pulse, step_count=3.
- Glitch rejection: pulses of 1 and 13 cycles -> btn_level stays 0, no step_pulse, step_count unchanged; a following 36-cycle press still yields exactly 1 pulse.
- Free-run: run_mode=1, run_div=3 for 40 cycles -> cpu_en high once every 4 cycles (10 pulses ±1); run_div=0 -> cpu_en continuously 1; step_count tracks both exactly.
- halt: run_mode=1, run_div=0, halt=1 for 5 cycles -> cpu_en=0 for those 5 cycles, step_count frozen, then resumes; halt coinciding with a step pulse in STEP mode -> no cpu_en.
- Wrap and mid-operation reset: preset 0xFFFE enables then 2 more -> step_count=0x0000; reset asserted mid-press -> immediate clear, no stale step_pulse after release.
